// File: rtl/acc_stack.sv
// acc_stack: parametrised accumulator with carry/zero flags and a DEPTH-entry
// LIFO of {acc, C, Z} snapshots for context save/restore.
//
// Ports:
//   CLK, CLR          clock, synchronous active-high reset
//   A_imm             immediate operand (zero- or sign-extended to WIDTH)
//   B_rf, B_alu       register-file operand, ALU result
//   SelAcc            00 immediate, 01 B_rf, 1x B_alu
//   LoadAcc           load selected source and cin/zin into acc/flags
//   Push, Pop         save / restore snapshot (both = swap with top)
//   ErrClr            clear sticky err (a new error in the same cycle wins)
//   cin, zin          flag inputs
//   acc_out, cout, zout  registered accumulator and flags
//   depth             occupied entries, 0..DEPTH
//   full, empty       decoded from depth
//   err               sticky overflow/underflow flag
module acc_stack #(
  parameter int WIDTH    = 8,
  parameter int IMM_W    = 4,
  parameter int DEPTH    = 4,
  parameter int SIGN_EXT = 0
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic [IMM_W-1:0]           A_imm,
  input  logic [WIDTH-1:0]           B_rf,
  input  logic [WIDTH-1:0]           B_alu,
  input  logic [1:0]                 SelAcc,
  input  logic                       LoadAcc,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic                       ErrClr,
  input  logic                       cin,
  input  logic                       zin,
  output logic [WIDTH-1:0]           acc_out,
  output logic                       cout,
  output logic                       zout,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam int EW = WIDTH + 2;  // {acc, C, Z}

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             zout_q, zout_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;

  // Snapshot storage; read asynchronously because a pop must land in the
  // accumulator on the same edge it is sampled.
  logic [EW-1:0]    mem_q [DEPTH];

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] src_sel;
  logic [EW-1:0]    cur_snap;
  logic [EW-1:0]    top_snap;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic [EW-1:0]    wr_data;
  logic             wr_en;
  logic             new_err;
  logic             is_full;
  logic             is_empty;

  // Immediate extension, bit by bit so IMM_W == WIDTH needs no special case.
  always_comb begin
    imm_ext = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < IMM_W)
        imm_ext[i] = A_imm[i];
      else if (SIGN_EXT != 0)
        imm_ext[i] = A_imm[IMM_W-1];
      else
        imm_ext[i] = 1'b0;
    end
  end

  always_comb begin
    unique case (SelAcc)
      2'b00:   src_sel = imm_ext;
      2'b01:   src_sel = B_rf;
      default: src_sel = B_alu;
    endcase
  end

  assign is_full  = (depth_q == DW'(DEPTH));
  assign is_empty = (depth_q == '0);
  assign cur_snap = {acc_q, cout_q, zout_q};
  // When empty this index wraps to DEPTH-1; it is never used in that case.
  assign top_idx  = depth_q[AW-1:0] - 1'b1;
  assign top_snap = mem_q[top_idx];

  always_comb begin
    acc_d   = acc_q;
    cout_d  = cout_q;
    zout_d  = zout_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = depth_q[AW-1:0];
    wr_data = cur_snap;
    new_err = 1'b0;

    unique case ({Push, Pop})
      2'b11: begin
        // Swap: top entry and live accumulator exchange places.
        if (!is_empty) begin
          {acc_d, cout_d, zout_d} = top_snap;
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          new_err = 1'b1;
        end
      end
      2'b01: begin
        if (!is_empty) begin
          {acc_d, cout_d, zout_d} = top_snap;
          depth_d = depth_q - 1'b1;
        end else begin
          new_err = 1'b1;
        end
      end
      2'b10: begin
        if (!is_full) begin
          wr_en   = 1'b1;
          depth_d = depth_q + 1'b1;
        end else begin
          new_err = 1'b1;
        end
        // The pre-edge value is saved, so a load in the same cycle is safe.
        if (LoadAcc) begin
          acc_d  = src_sel;
          cout_d = cin;
          zout_d = zin;
        end
      end
      default: begin
        if (LoadAcc) begin
          acc_d  = src_sel;
          cout_d = cin;
          zout_d = zin;
        end
      end
    endcase

    if (new_err)
      err_d = 1'b1;
    else if (ErrClr)
      err_d = 1'b0;
    else
      err_d = err_q;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      acc_q   <= '0;
      cout_q  <= 1'b0;
      zout_q  <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      zout_q  <= zout_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; reset only suppresses the write.
  always_ff @(posedge CLK) begin
    if (wr_en && !CLR)
      mem_q[wr_idx] <= wr_data;
  end

  assign acc_out = acc_q;
  assign cout    = cout_q;
  assign zout    = zout_q;
  assign depth   = depth_q;
  assign err     = err_q;
  assign full    = is_full;
  assign empty   = is_empty;

endmodule

// File: tb/tb_acc_stack.sv
module tb_acc_stack;

  localparam int WIDTH = 8;
  localparam int IMM_W = 4;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             CLR = 1'b0;
  logic [IMM_W-1:0] A_imm = '0;
  logic [WIDTH-1:0] B_rf = '0;
  logic [WIDTH-1:0] B_alu = '0;
  logic [1:0]       SelAcc = '0;
  logic             LoadAcc = 1'b0;
  logic             Push = 1'b0;
  logic             Pop = 1'b0;
  logic             ErrClr = 1'b0;
  logic             cin = 1'b0;
  logic             zin = 1'b0;

  logic [WIDTH-1:0] acc_out;
  logic             cout, zout, full, empty, err;
  logic [2:0]       depth;

  logic [WIDTH-1:0] sx_acc_out;
  logic             sx_cout, sx_zout, sx_full, sx_empty, sx_err;
  logic [2:0]       sx_depth;

  int total = 0;
  int bad   = 0;

  // Reference state: accumulator, flags, and the stack as a queue of snapshots.
  logic [WIDTH-1:0] m_acc;
  logic             m_c, m_z, m_err;
  logic [WIDTH+1:0] m_stk[$];

  always #5 CLK = ~CLK;

  acc_stack #(.WIDTH(WIDTH), .IMM_W(IMM_W), .DEPTH(DEPTH), .SIGN_EXT(0)) dut (
    .CLK(CLK), .CLR(CLR), .A_imm(A_imm), .B_rf(B_rf), .B_alu(B_alu),
    .SelAcc(SelAcc), .LoadAcc(LoadAcc), .Push(Push), .Pop(Pop),
    .ErrClr(ErrClr), .cin(cin), .zin(zin),
    .acc_out(acc_out), .cout(cout), .zout(zout), .depth(depth),
    .full(full), .empty(empty), .err(err)
  );

  acc_stack #(.WIDTH(WIDTH), .IMM_W(IMM_W), .DEPTH(DEPTH), .SIGN_EXT(1)) dut_sx (
    .CLK(CLK), .CLR(CLR), .A_imm(A_imm), .B_rf(B_rf), .B_alu(B_alu),
    .SelAcc(SelAcc), .LoadAcc(LoadAcc), .Push(Push), .Pop(Pop),
    .ErrClr(ErrClr), .cin(cin), .zin(zin),
    .acc_out(sx_acc_out), .cout(sx_cout), .zout(sx_zout), .depth(sx_depth),
    .full(sx_full), .empty(sx_empty), .err(sx_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference step, written from the command rules on the queue.
  task automatic model_step();
    logic [WIDTH-1:0] src;
    logic [WIDTH+1:0] tmp;
    bit e;
    e = 0;
    case (SelAcc)
      2'b00:   src = {{(WIDTH-IMM_W){1'b0}}, A_imm};
      2'b01:   src = B_rf;
      default: src = B_alu;
    endcase
    if (CLR) begin
      m_acc = '0; m_c = 0; m_z = 0; m_err = 0;
      m_stk.delete();
      return;
    end
    if (Push && Pop) begin
      if (m_stk.size() == 0) e = 1;
      else begin
        tmp = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = {m_acc, m_c, m_z};
        {m_acc, m_c, m_z} = tmp;
      end
    end else if (Pop) begin
      if (m_stk.size() == 0) e = 1;
      else {m_acc, m_c, m_z} = m_stk.pop_back();
    end else begin
      if (Push) begin
        if (m_stk.size() == DEPTH) e = 1;
        else m_stk.push_back({m_acc, m_c, m_z});
      end
      if (LoadAcc) begin
        m_acc = src; m_c = cin; m_z = zin;
      end
    end
    if (e) m_err = 1;
    else if (ErrClr) m_err = 0;
  endtask

  task automatic cyc(input bit clr, input bit push, input bit pop, input bit load,
                     input logic [1:0] sel, input logic [3:0] imm, input logic [7:0] rf,
                     input logic [7:0] alu, input bit ci, input bit zi, input bit eclr);
    CLR = clr; Push = push; Pop = pop; LoadAcc = load; SelAcc = sel;
    A_imm = imm; B_rf = rf; B_alu = alu; cin = ci; zin = zi; ErrClr = eclr;
    model_step();
    @(posedge CLK);
    #1;
    $display("cyc clr=%0b push=%0b pop=%0b load=%0b sel=%0d -> acc=%02h c=%0b z=%0b depth=%0d err=%0b",
             clr, push, pop, load, sel, acc_out, cout, zout, depth, err);
    check("acc", 32'(acc_out), 32'(m_acc));
    check("cout", 32'(cout), 32'(m_c));
    check("zout", 32'(zout), 32'(m_z));
    check("depth", 32'(depth), 32'(m_stk.size()));
    check("full", 32'(full), 32'(m_stk.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_stk.size() == 0));
    check("err", 32'(err), 32'(m_err));
  endtask

  // Shorthand: load B_alu with flags.
  task automatic ld(input logic [7:0] v, input bit ci, input bit zi);
    cyc(0, 0, 0, 1, 2'b10, 4'h0, 8'h00, v, ci, zi, 0);
  endtask

  initial begin
    m_acc = '0; m_c = 0; m_z = 0; m_err = 0;

    // Reset, then reset in the middle of activity.
    cyc(1, 0, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    ld(8'h5A, 1, 0);
    cyc(0, 1, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 1, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    check("pre_clr_depth", 32'(depth), 32'd2);
    cyc(1, 1, 0, 1, 2'b10, 4'h0, 8'h00, 8'hFF, 1, 1, 0);
    check("clr_acc", 32'(acc_out), 32'h00);
    check("clr_empty", 32'(empty), 32'd1);

    // Source select and immediate extension.
    cyc(0, 0, 0, 1, 2'b00, 4'hB, 8'h00, 8'h00, 0, 0, 0);
    check("imm_zext", 32'(acc_out), 32'h0B);
    check("imm_sext", 32'(sx_acc_out), 32'hFB);
    cyc(0, 0, 0, 1, 2'b01, 4'h0, 8'h3C, 8'h00, 0, 0, 0);
    check("rf_load", 32'(acc_out), 32'h3C);
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 8'h00, 8'h00, 1, 1, 0);

    // Push with load in the same cycle, then pop.
    ld(8'h11, 1, 0);
    cyc(0, 1, 0, 1, 2'b10, 4'h0, 8'h00, 8'h22, 0, 0, 0);
    check("pushload_acc", 32'(acc_out), 32'h22);
    cyc(0, 0, 1, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    check("pop_restore", 32'({acc_out, cout, zout}), 32'({8'h11, 1'b1, 1'b0}));

    // Fill, overflow, drain.
    for (int i = 1; i <= 4; i++) begin
      ld(8'(i), 0, 0);
      cyc(0, 1, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    end
    check("fill_full", 32'(full), 32'd1);
    cyc(0, 1, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    check("ovf_err", 32'(err), 32'd1);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 0, 1, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
      check("drain", 32'(acc_out), 32'(i));
    end

    // Underflow with load ignored; clear; clear racing a new error.
    cyc(0, 0, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 1);
    cyc(0, 0, 1, 1, 2'b10, 4'h0, 8'h00, 8'h77, 1, 1, 0);
    check("udf_acc", 32'(acc_out), 32'h01);
    cyc(0, 0, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 1);
    check("errclr", 32'(err), 32'd0);
    cyc(0, 0, 1, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 1);
    check("errclr_vs_new", 32'(err), 32'd1);

    // Swap.
    cyc(0, 0, 0, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 1);
    ld(8'h55, 0, 1);
    cyc(0, 1, 0, 1, 2'b10, 4'h0, 8'h00, 8'hAA, 1, 0, 0);
    cyc(0, 1, 1, 1, 2'b10, 4'h0, 8'h00, 8'hEE, 0, 0, 0);
    check("swap_acc", 32'(acc_out), 32'h55);
    check("swap_depth", 32'(depth), 32'd1);
    cyc(0, 0, 1, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    check("swap_top", 32'(acc_out), 32'hAA);
    cyc(0, 1, 1, 0, 2'b00, 4'h0, 8'h00, 8'h00, 0, 0, 0);
    check("swap_empty_err", 32'(err), 32'd1);

    // Randomized traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, 2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
